// File: rtl/core_pkg.sv
// Shared types and constants for the single-cycle RISC-V core front end.
// Holds the PC-unit state encoding and the target alignment helper.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES_RV32     = 4;

  // Only the two LSBs matter: 2-byte steps need bit 0 clear, 4-byte steps need both clear.
  function automatic logic is_misaligned(input logic [1:0] lsbs, input int unsigned instr_bytes);
    return (instr_bytes == 2) ? lsbs[0] : (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: clocked state uses <= so every flop samples pre-edge values; combinational blocks use =.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: BOOT/RUN/HALT FSM, next-PC selection, sticky misalignment flag
// and a saturating count of accepted fetches.
module pc_unit
  import core_pkg::*;
#(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned          INSTR_BYTES  = INSTR_BYTES_RV32,
  parameter int unsigned          CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [XLEN-1:0]      pc,
  output logic [XLEN-1:0]      pc_next_seq,
  output logic                 fetch_valid,
  output logic                 misaligned,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            fetch_inc;
  logic            target_bad;

  assign pc_next_seq = pc_q + XLEN'(INSTR_BYTES);
  assign target_bad  = is_misaligned(redirect_target[1:0], INSTR_BYTES);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mis_d     = mis_q;
    fetch_inc = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (redirect_valid && target_bad) begin
          mis_d   = 1'b1;
          state_d = HALT;
        end else if (redirect_valid) begin
          // A taken redirect flushes, so it beats stall.
          pc_d      = redirect_target;
          fetch_inc = 1'b1;
        end else if (!stall) begin
          pc_d      = pc_next_seq;
          fetch_inc = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          if (!redirect_valid) begin
            state_d = RUN;
            mis_d   = 1'b0;
          end else if (!target_bad) begin
            pc_d    = redirect_target;
            state_d = RUN;
            mis_d   = 1'b0;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (fetch_inc),
    .clr   (1'b0),
    .count (fetch_count)
  );

  assign pc          = pc_q;
  assign fetch_valid = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 4-byte/4-bit-counter instance and a 2-byte instance
// at RESET_VECTOR 0x1000 share one stimulus set.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;

  logic [31:0] pc_a, nseq_a, pc_b, nseq_b;
  logic        fv_a, mis_a, hlt_a, fv_b, mis_b, hlt_b;
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .pc(pc_a), .pc_next_seq(nseq_a), .fetch_valid(fv_a), .misaligned(mis_a),
    .halted(hlt_a), .fetch_count(cnt_a)
  );

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .INSTR_BYTES(2), .CNT_WIDTH(32)) u_dut_b (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt_req(halt_req), .resume(resume),
    .pc(pc_b), .pc_next_seq(nseq_b), .fetch_valid(fv_b), .misaligned(mis_b),
    .halted(hlt_b), .fetch_count(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  // One clock: inputs set now are sampled on the next edge; outputs settle 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in BOOT, 1 time unit after an edge.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_a(input string tag, input logic [31:0] epc, input logic efv,
                         input logic ehlt, input logic emis, input logic [3:0] ecnt);
    check({tag, ".pc"},  64'(pc_a),  64'(epc));
    check({tag, ".fv"},  64'(fv_a),  64'(efv));
    check({tag, ".hlt"}, 64'(hlt_a), 64'(ehlt));
    check({tag, ".mis"}, 64'(mis_a), 64'(emis));
    check({tag, ".cnt"}, 64'(cnt_a), 64'(ecnt));
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // Reset and boot
    do_reset();
    check_a("boot", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("boot.nseq", 64'(nseq_a), 64'h4);
    step(); check_a("run0", 32'h0, 1'b1, 1'b0, 1'b0, 4'd0);
    step(); check_a("run1", 32'h4, 1'b1, 1'b0, 1'b0, 4'd1);
    step(); check_a("run2", 32'h8, 1'b1, 1'b0, 1'b0, 4'd2);
    step(); check_a("run3", 32'hC, 1'b1, 1'b0, 1'b0, 4'd3);

    // Stall, then redirect overriding stall
    step(); check_a("at10", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);
    stall = 1'b1;
    step(); check_a("stall1", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);
    step(); check_a("stall2", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step(); check_a("redir_stall", 32'h40, 1'b1, 1'b0, 1'b0, 4'd5);

    // Misaligned redirect, failed resume, successful resume
    stall = 1'b0; redirect_target = 32'h22;
    step(); check_a("misal", 32'h40, 1'b0, 1'b1, 1'b1, 4'd5);
    resume = 1'b1; redirect_target = 32'h102;
    step(); check_a("resume_bad", 32'h40, 1'b0, 1'b1, 1'b1, 4'd5);
    redirect_target = 32'h100;
    step(); check_a("resume_tgt", 32'h100, 1'b1, 1'b0, 1'b0, 4'd5);
    idle();
    step(); check_a("after_res", 32'h104, 1'b1, 1'b0, 1'b0, 4'd6);

    // Halt / resume
    do_reset();
    step(); step(); step();
    check_a("h_at8", 32'h8, 1'b1, 1'b0, 1'b0, 4'd2);
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80;
    step(); check_a("halt", 32'h8, 1'b0, 1'b1, 1'b0, 4'd2);
    idle();
    for (int i = 0; i < 5; i++) begin
      step(); check_a("held", 32'h8, 1'b0, 1'b1, 1'b0, 4'd2);
    end
    resume = 1'b1;
    step(); check_a("resume", 32'h8, 1'b1, 1'b0, 1'b0, 4'd2);
    resume = 1'b0;
    step(); check_a("res_next", 32'hC, 1'b1, 1'b0, 1'b0, 4'd3);
    halt_req = 1'b1;
    step(); check_a("halt2", 32'hC, 1'b0, 1'b1, 1'b0, 4'd3);
    resume = 1'b1;
    step(); check_a("res_wins", 32'hC, 1'b1, 1'b0, 1'b0, 4'd3);
    idle();
    step(); check_a("res_wins_n", 32'h10, 1'b1, 1'b0, 1'b0, 4'd4);

    // Wrap-around and counter saturation (CNT_WIDTH=4)
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(); check_a("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 4'd1);
    check("top.nseq", 64'(nseq_a), 64'h0);
    idle();
    step(); check_a("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 4'd2);
    repeat (20) step();
    check_a("sat", 32'h50, 1'b1, 1'b0, 1'b0, 4'd15);

    // Asynchronous reset between edges
    do_reset();
    step();
    repeat (12) step();
    check_a("pre_arst", 32'h30, 1'b1, 1'b0, 1'b0, 4'd12);
    #2 reset = 1'b1;
    #1 check_a("arst", 32'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // 2-byte instance at RESET_VECTOR 0x1000
    do_reset();
    check("b.boot.pc", 64'(pc_b), 64'h1000);
    check("b.boot.fv", 64'(fv_b), 64'h0);
    step(); check("b.run0.pc", 64'(pc_b), 64'h1000);
    check("b.run0.fv", 64'(fv_b), 64'h1);
    check("b.run0.nseq", 64'(nseq_b), 64'h1002);
    step(); check("b.run1.pc", 64'(pc_b), 64'h1002);
    step(); check("b.run2.pc", 64'(pc_b), 64'h1004);
    check("b.run2.cnt", 64'(cnt_b), 64'd2);
    redirect_valid = 1'b1; redirect_target = 32'h1006;
    step(); check("b.al.pc", 64'(pc_b), 64'h1006);
    check("b.al.mis", 64'(mis_b), 64'h0);
    redirect_target = 32'h1001;
    step(); check("b.mis.mis", 64'(mis_b), 64'h1);
    check("b.mis.hlt", 64'(hlt_b), 64'h1);
    check("b.mis.pc", 64'(pc_b), 64'h1006);
    check("b.mis.cnt", 64'(cnt_b), 64'd3);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
